// File: rtl/serial_stim_tx.sv
// Serial stimulus transmitter: accepts parallel words over valid/ready and
// shifts them out LSB-first, one bit per clock, while counting transmitted 1-bits.
module serial_stim_tx #(
  parameter int WIDTH = 32,
  parameter int GAP   = 0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             tx_active,
  output logic             word_done,
  output logic [CNT_W-1:0] ones_sent
);

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               data_out_q;
  logic               tx_active_q;
  logic               word_done_q;
  logic [CNT_W-1:0]   ones_q;

  logic last_bit;
  logic accept;

  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
  // With no forced gap the last-bit cycle can already take the next word.
  assign in_ready = (state_q == S_IDLE) || (last_bit && (GAP == 0));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      data_out_q  <= 1'b0;
      tx_active_q <= 1'b0;
      word_done_q <= 1'b0;
      ones_q      <= '0;
    end else begin
      word_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: ;
        S_SHIFT: begin
          ones_q    <= ones_q + CNT_W'(data_out_q);
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          // data_out mirrors the bit that becomes shift_q[0] after this edge.
          data_out_q <= shift_q[1];
          if (last_bit) begin
            word_done_q <= 1'b1;
            data_out_q  <= 1'b0;
            tx_active_q <= 1'b0;
            gap_cnt_q   <= '0;
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == LAST_GAP) state_q <= S_IDLE;
          else                       gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      // NOTE: later non-blocking assignments win, so acceptance overrides the
      // end-of-word updates above while the count and word_done still land.
      if (accept) begin
        shift_q     <= in_data;
        bit_cnt_q   <= '0;
        data_out_q  <= in_data[0];
        tx_active_q <= 1'b1;
        state_q     <= S_SHIFT;
      end
    end
  end

  assign data_out  = data_out_q;
  assign tx_active = tx_active_q;
  assign word_done = word_done_q;
  assign ones_sent = ones_q;

endmodule

// File: tb/tb_serial_stim_tx.sv
// Scoreboard bench for serial_stim_tx: two instances (32-bit/no gap and
// 8-bit/gap 3/4-bit counter) checked bit-by-bit against a queue-based model.
module tb_serial_stim_tx;

  localparam int WA = 32, GA = 0, CA = 32;
  localparam int WB = 8,  GB = 3, CB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [WA-1:0] a_data;
  logic          a_valid, a_ready, a_dout, a_act, a_done;
  logic [CA-1:0] a_ones;
  logic [WB-1:0] b_data;
  logic          b_valid, b_ready, b_dout, b_act, b_done;
  logic [CB-1:0] b_ones;

  serial_stim_tx #(.WIDTH(WA), .GAP(GA), .CNT_W(CA)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .data_out(a_dout), .tx_active(a_act),
    .word_done(a_done), .ones_sent(a_ones));

  serial_stim_tx #(.WIDTH(WB), .GAP(GB), .CNT_W(CB)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .data_out(b_dout), .tx_active(b_act),
    .word_done(b_done), .ones_sent(b_ones));

  typedef struct {
    bit b;
    bit last;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  longint unsigned exp_ones[2];
  int  free_cyc[2];
  bit  done_pend[2];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(int id);
    return (id != 0) ? qb.size() : qa.size();
  endfunction

  function automatic exp_t qfront(int id);
    return (id != 0) ? qb[0] : qa[0];
  endfunction

  function automatic exp_t qpop(int id);
    return (id != 0) ? qb.pop_front() : qa.pop_front();
  endfunction

  // Reference model: a word accepted at edge n yields bit k in cycle n+k.
  function automatic void push_word(int id, logic [31:0] w, int n);
    int wd = (id != 0) ? WB : WA;
    int g  = (id != 0) ? GB : GA;
    for (int k = 0; k < wd; k++) begin
      exp_t e;
      e.b = w[k];
      e.last = (k == wd - 1);
      e.cyc = n + k;
      if (id != 0) qb.push_back(e); else qa.push_back(e);
    end
    free_cyc[id] = n + wd - 1 + ((g > 0) ? g + 1 : 0);
  endfunction

  function automatic void model_clear();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      exp_ones[i]  = 0;
      free_cyc[i]  = 0;
      done_pend[i] = 1'b0;
    end
  endfunction

  task automatic mon(int id, logic dout, logic act, logic done, logic rdy,
                     logic [63:0] ones);
    int c = (id != 0) ? CB : CA;
    string tag = (id != 0) ? "b" : "a";
    exp_t e;
    check({tag, ".in_ready"}, rdy, cyc >= free_cyc[id]);
    check({tag, ".word_done"}, done, done_pend[id]);
    done_pend[id] = 1'b0;
    check({tag, ".ones_sent"}, ones, exp_ones[id] % (64'd1 << c));
    if (act) begin
      if (qsize(id) == 0) begin
        check({tag, ".tx_active_unexpected"}, act, 0);
      end else begin
        e = qpop(id);
        check({tag, ".bit_cycle"}, cyc, e.cyc);
        check({tag, ".data_out"}, dout, e.b);
        exp_ones[id] += e.b;
        if (e.last) done_pend[id] = 1'b1;
      end
    end else begin
      check({tag, ".data_out_idle"}, dout, 0);
      if (qsize(id) != 0 && qfront(id).cyc <= cyc) begin
        check({tag, ".tx_active_missing"}, act, 1);
        e = qpop(id);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, a_dout, a_act, a_done, a_ready, 64'(a_ones));
      mon(1, b_dout, b_act, b_done, b_ready, 64'(b_ones));
    end
  end

  task automatic drive(int id, bit v, logic [31:0] w);
    if (id != 0) begin b_valid = v; b_data = w[WB-1:0]; end
    else         begin a_valid = v; a_data = w; end
  endtask

  // Offers a word and holds valid until the model says it is accepted.
  task automatic send(int id, logic [31:0] w);
    int budget = 200;
    @(negedge clk); #1;
    drive(id, 1'b1, w);
    while (cyc < free_cyc[id]) begin
      @(negedge clk); #1;
      budget--;
      if (budget == 0) begin
        check("send_timeout", 0, 1);
        drive(id, 1'b0, w);
        return;
      end
    end
    push_word(id, w, cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(int id, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      drive(id, 1'b0, $urandom);
    end
  endtask

  task automatic drain(int id);
    int budget = 2000;
    @(negedge clk); #1;
    drive(id, 1'b0, $urandom);
    while (qsize(id) != 0 || done_pend[id] || cyc < free_cyc[id]) begin
      @(negedge clk); #1;
      budget--;
      if (budget == 0) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  // Asserts reset away from any clock edge and checks outputs clear at once.
  task automatic pulse_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst.a_data_out", a_dout, 0);
    check("rst.a_tx_active", a_act, 0);
    check("rst.a_word_done", a_done, 0);
    check("rst.a_ones_sent", 64'(a_ones), 0);
    check("rst.b_data_out", b_dout, 0);
    check("rst.b_tx_active", b_act, 0);
    check("rst.b_word_done", b_done, 0);
    check("rst.b_ones_sent", 64'(b_ones), 0);
    model_clear();
    drive(0, 1'b0, $urandom);
    drive(1, 1'b0, $urandom);
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst.a_in_ready", a_ready, 1);
    check("rst.b_in_ready", b_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (2) @(posedge clk);
    pulse_reset();

    // Single word 0x5 from reset.
    send(0, 32'h0000_0005);
    drain(0);
    check("single.ones_sent", 64'(a_ones), 2);

    // Back-to-back words with valid held high.
    @(posedge clk);
    pulse_reset();
    send(0, 32'hFFFF_FFFF);
    send(0, 32'h8000_0001);
    drain(0);
    check("b2b.ones_sent", 64'(a_ones), 34);

    // Reset in the middle of a word, then a fresh word.
    @(posedge clk);
    pulse_reset();
    send(0, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    check("midword.ones_before", 64'(a_ones), 10);
    check("midword.data_out_before", a_dout, 1);
    pulse_reset();
    send(0, 32'h0000_00A5);
    drain(0);
    check("midword.ones_after", 64'(a_ones), 4);

    // Randomized traffic on the no-gap instance.
    for (int i = 0; i < 20; i++) begin
      send(0, $urandom);
      if ($urandom_range(0, 2) != 0) idle(0, $urandom_range(1, 3));
    end
    drain(0);

    // Forced gap and counter wrap on the 8-bit instance.
    send(1, 32'h0000_00FF);
    send(1, 32'h0000_00FF);
    check("wrap.ones_first", 64'(b_ones), 8);
    drain(1);
    check("wrap.ones_second", 64'(b_ones), 0);

    for (int i = 0; i < 15; i++) begin
      send(1, $urandom);
      if ($urandom_range(0, 1) != 0) idle(1, $urandom_range(1, 6));
    end
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
